// File: rtl/alu_result_demux.sv
// ALU result demux: steers each result into one of two per-destination FIFOs
// (out0 = writeback, out1 = LSU address). Optional stats under `DEMUX_STATS_EN.

module alu_result_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rd];
  // Pop is ignored while empty; push is pre-qualified by the top-level in_ready.
  assign w_pop   = i_pop && o_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module alu_result_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [15:0]      stat_acc0,
  output logic [15:0]      stat_acc1,
  output logic [15:0]      stat_stall
);
  logic [1:0]            w_full, w_valid, w_rdy, w_acc;
  logic [1:0][WIDTH-1:0] w_data;

  // Full is registered state, so a same-cycle pop cannot open the input.
  assign in_ready = !rst && !w_full[in_sel];
  assign w_rdy    = {out1_ready, out0_ready};

  for (genvar g = 0; g < 2; g++) begin : g_dst
    assign w_acc[g] = in_valid && in_ready && (in_sel == 1'(g));
    alu_result_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_acc[g]),
      .i_data  (in_data),
      .i_pop   (w_rdy[g]),
      .o_full  (w_full[g]),
      .o_data  (w_data[g]),
      .o_valid (w_valid[g])
    );
  end

  assign out0_data  = w_data[0];
  assign out0_valid = w_valid[0];
  assign out1_data  = w_data[1];
  assign out1_valid = w_valid[1];

`ifdef DEMUX_STATS_EN
  logic [15:0] r_acc0, r_acc1, r_stall;

  // Saturating; flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc0  <= '0;
      r_acc1  <= '0;
      r_stall <= '0;
    end else begin
      if (w_acc[0] && r_acc0 != 16'hFFFF) r_acc0 <= r_acc0 + 16'd1;
      if (w_acc[1] && r_acc1 != 16'hFFFF) r_acc1 <= r_acc1 + 16'd1;
      if (in_valid && !in_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end
  end

  assign stat_acc0  = r_acc0;
  assign stat_acc1  = r_acc1;
  assign stat_stall = r_stall;
`else
  assign stat_acc0  = 16'h0000;
  assign stat_acc1  = 16'h0000;
  assign stat_stall = 16'h0000;
`endif
endmodule

// File: tb/tb_alu_result_demux.sv
// Directed bench for alu_result_demux (WIDTH=32, DEPTH=2); stats expectations follow `DEMUX_STATS_EN.
`timescale 1ns/1ps
module tb_alu_result_demux;
  logic        clk = 1'b0;
  logic        rst, flush, in_sel, in_valid, in_ready;
  logic [31:0] in_data, out0_data, out1_data;
  logic        out0_valid, out0_ready, out1_valid, out1_ready;
  logic [15:0] stat_acc0, stat_acc1, stat_stall;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_result_demux #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .stat_acc0(stat_acc0), .stat_acc1(stat_acc1), .stat_stall(stat_stall)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic sel, input logic [31:0] d);
    in_valid = 1'b1; in_sel = sel; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_sel = 1'b0; in_valid = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #2;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_v0", {31'b0, out0_valid}, 32'd0);
    chk("rst_v1", {31'b0, out1_valid}, 32'd0);
    chk("rst_d0", out0_data, 32'd0);
    chk("rst_d1", out1_data, 32'd0);
    chk("rst_stall", {16'b0, stat_stall}, 32'd0);
    tick(); rst = 1'b0; tick();

    // 1: single word to out0, one-cycle latency
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5_0001; out0_ready = 1'b1;
    #1 chk("t1_ready", {31'b0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    #1 chk("t1_v0", {31'b0, out0_valid}, 32'd1);
    chk("t1_d0", out0_data, 32'hA5A5_0001);
    chk("t1_v1", {31'b0, out1_valid}, 32'd0);
    tick();
    chk("t1_v0_drained", {31'b0, out0_valid}, 32'd0);

    // 2: FIFO1 fills while FIFO0 still accepts; order preserved
    out1_ready = 1'b0;
    push(1'b1, 32'd1); push(1'b1, 32'd2);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'd9;
    #1 chk("t2_full1", {31'b0, in_ready}, 32'd0);
    in_sel = 1'b0; in_data = 32'd3;
    #1 chk("t2_sel0_ok", {31'b0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk("t2_d0", out0_data, 32'd3);
    chk("t2_d1_first", out1_data, 32'd1);
    out1_ready = 1'b1;
    tick();
    chk("t2_d1_second", out1_data, 32'd2);
    chk("t2_v1_second", {31'b0, out1_valid}, 32'd1);
    tick();
    chk("t2_v1_empty", {31'b0, out1_valid}, 32'd0);
    chk("t2_v0_empty", {31'b0, out0_valid}, 32'd0);

    // 3: full FIFO0 with pop offered: push refused this cycle, taken next
    out0_ready = 1'b0;
    push(1'b0, 32'd10); push(1'b0, 32'd11);
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd12;
    #1 chk("t3_refused", {31'b0, in_ready}, 32'd0);
    tick();
    chk("t3_ready_next", {31'b0, in_ready}, 32'd1);
    chk("t3_head11", out0_data, 32'd11);
    tick(); in_valid = 1'b0;
    chk("t3_head12", out0_data, 32'd12);
    tick();
    chk("t3_empty", {31'b0, out0_valid}, 32'd0);

    // 4: flush with both FIFOs full and a word offered
    out0_ready = 1'b0; out1_ready = 1'b0;
    push(1'b0, 32'd20); push(1'b0, 32'd21); push(1'b1, 32'd30); push(1'b1, 32'd31);
    flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd99;
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("t4_v0", {31'b0, out0_valid}, 32'd0);
    chk("t4_v1", {31'b0, out1_valid}, 32'd0);
    // flush drops a word that was handshaked in the same cycle
    push(1'b0, 32'd60);
    flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd61;
    #1 chk("t4_ready_flush", {31'b0, in_ready}, 32'd1);
    tick(); flush = 1'b0; in_valid = 1'b0;
    chk("t4_v0_after", {31'b0, out0_valid}, 32'd0);
    out0_ready = 1'b1;
    push(1'b0, 32'd62);
    chk("t4_d0_fresh", out0_data, 32'd62);
    tick();
    chk("t4_v0_one_word", {31'b0, out0_valid}, 32'd0);

    // 5: async reset with FIFO1 holding a word
    out1_ready = 1'b0;
    push(1'b1, 32'd50);
    chk("t5_v1_before", {31'b0, out1_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("t5_v1_async", {31'b0, out1_valid}, 32'd0);
    chk("t5_d1_async", out1_data, 32'd0);
    in_sel = 1'b1;
    chk("t5_ready_rst", {31'b0, in_ready}, 32'd0);
    chk("t5_acc0", {16'b0, stat_acc0}, 32'd0);
    chk("t5_acc1", {16'b0, stat_acc1}, 32'd0);
    tick();
    chk("t5_ready_rst_hold", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("t5_ready_release", {31'b0, in_ready}, 32'd1);
    tick();

    // 6: statistics: 3 pushes to out0, 1 to out1, 4 stall cycles
    out0_ready = 1'b0; out1_ready = 1'b0;
    push(1'b1, 32'd70); push(1'b0, 32'd71); push(1'b0, 32'd72);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd73;
    #1 chk("t6_stalled", {31'b0, in_ready}, 32'd0);
    repeat (4) tick();
    in_valid = 1'b0; out0_ready = 1'b1;
    tick();
    out0_ready = 1'b0;
    push(1'b0, 32'd73);
    chk("t6_head", out0_data, 32'd72);
`ifdef DEMUX_STATS_EN
    chk("t6_acc0", {16'b0, stat_acc0}, 32'd3);
    chk("t6_acc1", {16'b0, stat_acc1}, 32'd1);
    chk("t6_stall", {16'b0, stat_stall}, 32'd4);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t6_acc0_flush", {16'b0, stat_acc0}, 32'd3);
`else
    chk("t6_acc0_off", {16'b0, stat_acc0}, 32'd0);
    chk("t6_acc1_off", {16'b0, stat_acc1}, 32'd0);
    chk("t6_stall_off", {16'b0, stat_stall}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
